multicycle_controller: RTL

- Parametrised multi-cycle successor to the single-cycle control unit of the accumulator CPU.
- Sequences FETCH/DECODE/EXEC through an explicit FSM.
- Waits on a memory ready handshake, with an optional timeout.
- Extends the ISA to a 4-bit opcode, reports faults, and counts retired instructions.

---
 rtl/multicycle_controller.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle FETCH/DECODE/EXEC control unit for the accumulator CPU.
//   It handles the memory ready handshake, with an optional wait timeout.
//   It detects illegal opcodes and counts retired instructions.
//
// Ports
//   clk, rst (async, active-low)     clock and reset
//   start                            leave HALT and begin fetching
//   opcode[3:0], ac[DATA_W-1:0]      instruction opcode and accumulator value
//   mem_ready                        memory handshake
//   rd_mem, wr_mem, ifetch, ld_ir,   combinational datapath strobes
//   pc_inc, pc_src, ac_src, ld_ac,
//   ld_imm, alu_add, alu_sub
//   halted, fault, fault_code[1:0]   status
//   state[2:0]                       FSM state (debug)
//   retired[CNT_W-1:0]               saturating retired-instruction count
module multicycle_controller #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] ac,
  input  logic              mem_ready,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic              ifetch,
  output logic              ld_ir,
  output logic              pc_inc,
  output logic              pc_src,
  output logic              ac_src,
  output logic              ld_ac,
  output logic              ld_imm,
  output logic              alu_add,
  output logic              alu_sub,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_STA  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JEZ  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_HLT  = 4'h7;
  localparam logic [3:0] OP_JNZ  = 4'h8;
  localparam logic [3:0] OP_JNEG = 4'h9;
  localparam logic [3:0] OP_NOP  = 4'hA;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ILLEGAL = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;

  // The wait counter only ever needs to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_r;
  state_t            next_s;
  logic [WAIT_W-1:0] wait_r;
  logic [1:0]        fault_code_r;
  logic [CNT_W-1:0]  retired_r;
  logic              retire_s;
  logic [1:0]        fault_set_s;
  logic              timeout_hit_s;
  logic              mem_wait_s;

  // A pending request times out only while mem_ready is low, so the handshake wins any tie.
  assign timeout_hit_s = (TIMEOUT > 0) && (wait_r == WAIT_LAST) && !mem_ready;

  assign state      = state_r;
  assign fault_code = fault_code_r;
  assign retired    = retired_r;

  // Next-state, strobe and status decode.
  always_comb begin
    next_s      = state_r;
    rd_mem      = 1'b0;
    wr_mem      = 1'b0;
    ifetch      = 1'b0;
    ld_ir       = 1'b0;
    pc_inc      = 1'b0;
    pc_src      = 1'b0;
    ac_src      = 1'b0;
    ld_ac       = 1'b0;
    ld_imm      = 1'b0;
    alu_add     = 1'b0;
    alu_sub     = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    retire_s    = 1'b0;
    fault_set_s = FC_NONE;
    mem_wait_s  = 1'b0;
    case (state_r)
      S_HALT: begin
        halted = 1'b1;
        if (start) next_s = S_FETCH;
        else       next_s = S_HALT;
      end
      S_FETCH: begin
        rd_mem = 1'b1;
        ifetch = 1'b1;
        if (mem_ready) begin
          ld_ir  = 1'b1;
          pc_inc = 1'b1;
          next_s = S_DECODE;
        end else if (timeout_hit_s) begin
          next_s      = S_FAULT;
          fault_set_s = FC_TIMEOUT;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_HLT: begin
            next_s   = S_HALT;
            retire_s = 1'b1;
          end
          OP_NOP: begin
            next_s   = S_FETCH;
            retire_s = 1'b1;
          end
          4'hB, 4'hC, 4'hD, 4'hE, 4'hF: begin
            next_s      = S_FAULT;
            fault_set_s = FC_ILLEGAL;
          end
          default: next_s = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_LDA: begin
            rd_mem     = 1'b1;
            ac_src     = 1'b1;
            ld_ac      = mem_ready;
            mem_wait_s = 1'b1;
          end
          OP_STA: begin
            wr_mem     = 1'b1;
            mem_wait_s = 1'b1;
          end
          OP_ADD: begin
            rd_mem     = 1'b1;
            alu_add    = 1'b1;
            ld_ac      = mem_ready;
            mem_wait_s = 1'b1;
          end
          OP_SUB: begin
            rd_mem     = 1'b1;
            alu_sub    = 1'b1;
            ld_ac      = mem_ready;
            mem_wait_s = 1'b1;
          end
          OP_JMP:  pc_src = 1'b1;
          OP_JEZ:  pc_src = (ac == '0);
          OP_LDI: begin
            ld_imm = 1'b1;
            ld_ac  = 1'b1;
          end
          OP_JNZ:  pc_src = (ac != '0);
          OP_JNEG: pc_src = ac[DATA_W-1];
          default: pc_src = 1'b0;
        endcase
        if (!mem_wait_s || mem_ready) begin
          next_s   = S_FETCH;
          retire_s = 1'b1;
        end else if (timeout_hit_s) begin
          next_s      = S_FAULT;
          fault_set_s = FC_TIMEOUT;
        end else begin
          next_s = S_EXEC;
        end
      end
      S_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
        next_s = S_FAULT;
      end
      default: next_s = S_HALT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= S_HALT;
    else      state_r <= next_s;
  end

  // Wait counter: counts unanswered request cycles within one state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  wait_r <= '0;
    else if ((next_s != state_r) || mem_ready) wait_r <= '0;
    else if (rd_mem || wr_mem)                 wait_r <= wait_r + WAIT_W'(1);
    else                                       wait_r <= wait_r;
  end

  // Fault code is captured on entry to FAULT and is only cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      fault_code_r <= FC_NONE;
    else if (fault_set_s != FC_NONE) fault_code_r <= fault_set_s;
    else                           fault_code_r <= fault_code_r;
  end

  // Retired-instruction counter, saturating at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             retired_r <= '0;
    else if (retire_s && (retired_r != '1)) retired_r <= retired_r + CNT_W'(1);
    else                                  retired_r <= retired_r;
  end

endmodule
